// File: rtl/clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clock_ctrl
// Purpose : HH:MM:SS BCD timekeeper with set-mode FSM and two-digit display
//           field scheduling. Optional blink via CLOCK_CTRL_BLINK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module clock_ctrl #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mode,
  input  logic       i_inc,
  input  logic       i_page,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [1:0] o_page,
  output logic       o_set,
  output logic       o_blank,
  output logic       o_sec_tick
);

  localparam int              PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   c_PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_pre;
  logic [7:0]      r_hh;
  logic [7:0]      r_mm;
  logic [7:0]      r_ss;
  logic [1:0]      r_page;
  logic            r_tick;
  logic            w_tick;
  logic [7:0]      w_disp;

  // Packed BCD field increment; wraps to 00 when the field maximum is reached.
  function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_tick = (r_state == ST_RUN) && (r_pre == c_PRE_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_pre   <= '0;
      r_hh    <= 8'h00;
      r_mm    <= 8'h00;
      r_ss    <= 8'h00;
      r_page  <= 2'd0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      case (r_state)
        ST_RUN: begin
          if (w_tick) begin
            r_pre <= '0;
            r_ss  <= f_bcd_inc(r_ss, 8'h59);
            if (r_ss == 8'h59) begin
              r_mm <= f_bcd_inc(r_mm, 8'h59);
              if (r_mm == 8'h59)
                r_hh <= f_bcd_inc(r_hh, 8'h23);
            end
          end else begin
            r_pre <= r_pre + PW'(1);
          end
          // A coinciding tick is still applied above; mode only drops page.
          if (i_mode) begin
            r_state <= ST_SET_H;
            r_pre   <= '0;
          end else if (i_page) begin
            r_page <= (r_page == 2'd2) ? 2'd0 : r_page + 2'd1;
          end
        end
        ST_SET_H: begin
          r_pre <= '0;
          if (i_mode)
            r_state <= ST_SET_M;
          else if (i_inc)
            r_hh <= f_bcd_inc(r_hh, 8'h23);
        end
        ST_SET_M: begin
          r_pre <= '0;
          if (i_mode) begin
            r_state <= ST_RUN;
            r_ss    <= 8'h00;
          end else if (i_inc) begin
            r_mm <= f_bcd_inc(r_mm, 8'h59);
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_pre   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_disp = r_hh;
    o_page = 2'd0;
    case (r_state)
      ST_SET_H: begin
        w_disp = r_hh;
        o_page = 2'd0;
      end
      ST_SET_M: begin
        w_disp = r_mm;
        o_page = 2'd1;
      end
      default: begin
        o_page = r_page;
        case (r_page)
          2'd1:    w_disp = r_mm;
          2'd2:    w_disp = r_ss;
          default: w_disp = r_hh;
        endcase
      end
    endcase
  end

  assign o_tens     = w_disp[7:4];
  assign o_ones     = w_disp[3:0];
  assign o_set      = (r_state != ST_RUN);
  assign o_sec_tick = r_tick;

`ifdef CLOCK_CTRL_BLINK_EN
  localparam int            BM          = CLK_HZ / 2;
  localparam int            BW          = (BM > 1) ? $clog2(BM) : 1;
  localparam logic [BW-1:0] c_BLINK_MAX = BW'(BM - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  // Any mode or inc pulse either enters a set state or is an accepted
  // increment, so both restart the blink visible.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == ST_RUN) || i_mode || i_inc) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == c_BLINK_MAX) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign o_blank = r_phase & (r_state != ST_RUN);
`else
  assign o_blank = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_ctrl.sv
`default_nettype none
// Testbench for clock_ctrl with CLK_HZ=10; directed scenarios, inline checks.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst, mode, inc, page;
  logic [3:0] tens, ones;
  logic [1:0] pg;
  logic       set, blank, tick;
  int         n_tests = 0;
  int         n_fail  = 0;

  clock_ctrl #(.CLK_HZ(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_inc(inc), .i_page(page),
    .o_tens(tens), .o_ones(ones), .o_page(pg), .o_set(set),
    .o_blank(blank), .o_sec_tick(tick)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_mode();
    mode = 1'b1; cyc(); mode = 1'b0;
  endtask

  task automatic pulse_page();
    page = 1'b1; cyc(); page = 1'b0;
  endtask

  task automatic incs(input int n);
    inc = 1'b1; cyc(n); inc = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; cyc(2);
    n_tests++;
    if ({tens, ones, pg, set, blank, tick} !== 13'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 0", {tens, ones, pg, set, blank, tick});
    end
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (tick) begin n = i; break; end
    end
    n_tests++;
    if (n != 10) begin
      n_fail++; $display("FAIL first_tick_cycle: got %0d required 10", n);
    end
    pulse_page(); pulse_page();
    n_tests++;
    if (pg !== 2'd2 || tens !== 4'd0 || ones !== 4'd1 || tick !== 1'b0) begin
      n_fail++; $display("FAIL ss_after_tick: got page=%0d %0d/%0d tick=%b required 2 0/1 0", pg, tens, ones, tick);
    end
  endtask

  task automatic test_set_hours();
    pulse_mode();
    n_tests++;
    if (set !== 1'b1 || pg !== 2'd0 || tens !== 4'd0 || ones !== 4'd0) begin
      n_fail++; $display("FAIL enter_set_h: got set=%b page=%0d %0d/%0d required 1 0 0/0", set, pg, tens, ones);
    end
    incs(25);
    n_tests++;
    if (set !== 1'b1 || pg !== 2'd0 || tens !== 4'd0 || ones !== 4'd1) begin
      n_fail++; $display("FAIL hours_wrap: got set=%b page=%0d %0d/%0d required 1 0 0/1", set, pg, tens, ones);
    end
  endtask

  task automatic test_minutes_wrap();
    int n;
    incs(4);
    pulse_mode();
    n_tests++;
    if (set !== 1'b1 || pg !== 2'd1 || {tens, ones} !== 8'h00) begin
      n_fail++; $display("FAIL enter_set_m: got set=%b page=%0d %0d/%0d required 1 1 0/0", set, pg, tens, ones);
    end
    incs(37);
    n_tests++;
    if ({tens, ones} !== 8'h37) begin
      n_fail++; $display("FAIL minutes_37: got %0d/%0d required 3/7", tens, ones);
    end
    incs(23);
    n_tests++;
    if ({tens, ones} !== 8'h00) begin
      n_fail++; $display("FAIL minutes_wrap: got %0d/%0d required 0/0", tens, ones);
    end
    pulse_mode();
    n_tests++;
    if (set !== 1'b0 || pg !== 2'd2 || {tens, ones} !== 8'h00) begin
      n_fail++; $display("FAIL exit_secs_clear: got set=%b page=%0d %0d/%0d required 0 2 0/0", set, pg, tens, ones);
    end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (tick) begin n = i; break; end
    end
    n_tests++;
    if (n != 10) begin
      n_fail++; $display("FAIL tick_after_exit: got %0d required 10", n);
    end
    pulse_page();
    n_tests++;
    if (pg !== 2'd0 || {tens, ones} !== 8'h05) begin
      n_fail++; $display("FAIL hours_no_carry: got page=%0d %0d/%0d required 0 0/5", pg, tens, ones);
    end
  endtask

  task automatic test_rollover();
    int nt;
    pulse_mode(); incs(18);
    pulse_mode(); incs(59);
    n_tests++;
    if ({tens, ones} !== 8'h59) begin
      n_fail++; $display("FAIL set_59: got %0d/%0d required 5/9", tens, ones);
    end
    pulse_mode();
    nt = 0;
    for (int i = 0; i < 599; i++) begin
      cyc();
      if (tick) nt++;
    end
    n_tests++;
    if (pg !== 2'd0 || {tens, ones} !== 8'h23 || nt != 59) begin
      n_fail++; $display("FAIL before_rollover: got page=%0d %0d/%0d ticks=%0d required 0 2/3 59", pg, tens, ones, nt);
    end
    cyc();
    n_tests++;
    if ({tens, ones} !== 8'h00 || tick !== 1'b1) begin
      n_fail++; $display("FAIL rollover_hh: got %0d/%0d tick=%b required 0/0 1", tens, ones, tick);
    end
    pulse_page();
    n_tests++;
    if (pg !== 2'd1 || {tens, ones} !== 8'h00) begin
      n_fail++; $display("FAIL rollover_mm: got page=%0d %0d/%0d required 1 0/0", pg, tens, ones);
    end
    pulse_page();
    n_tests++;
    if (pg !== 2'd2 || {tens, ones} !== 8'h00) begin
      n_fail++; $display("FAIL rollover_ss: got page=%0d %0d/%0d required 2 0/0", pg, tens, ones);
    end
    pulse_page();
  endtask

  task automatic test_simultaneous();
    pulse_mode();
    mode = 1'b1; inc = 1'b1; cyc(); mode = 1'b0; inc = 1'b0;
    n_tests++;
    if (set !== 1'b1 || pg !== 2'd1) begin
      n_fail++; $display("FAIL mode_beats_inc: got set=%b page=%0d required 1 1", set, pg);
    end
    pulse_page();
    n_tests++;
    if (pg !== 2'd1) begin
      n_fail++; $display("FAIL page_ignored_set_m: got %0d required 1", pg);
    end
    pulse_mode();
    n_tests++;
    if (set !== 1'b0 || pg !== 2'd0 || {tens, ones} !== 8'h00) begin
      n_fail++; $display("FAIL hours_unchanged: got set=%b page=%0d %0d/%0d required 0 0 0/0", set, pg, tens, ones);
    end
    cyc(9);
    pulse_mode();
    n_tests++;
    if (tick !== 1'b1 || set !== 1'b1) begin
      n_fail++; $display("FAIL tick_with_mode: got tick=%b set=%b required 1 1", tick, set);
    end
    pulse_mode(); pulse_mode();
  endtask

  task automatic test_reset_mid_set();
    logic [3:0] exp_b;
`ifdef CLOCK_CTRL_BLINK_EN
    exp_b = 4'b0110;
`else
    exp_b = 4'b0000;
`endif
    n_tests++;
    if (blank !== 1'b0 || set !== 1'b0) begin
      n_fail++; $display("FAIL blank_in_run: got %b required 0", blank);
    end
    pulse_mode();
    cyc(4);
    n_tests++;
    if (blank !== exp_b[3]) begin
      n_fail++; $display("FAIL blank_k4: got %b required %b", blank, exp_b[3]);
    end
    cyc();
    n_tests++;
    if (blank !== exp_b[2]) begin
      n_fail++; $display("FAIL blank_k5: got %b required %b", blank, exp_b[2]);
    end
    cyc(4);
    n_tests++;
    if (blank !== exp_b[1]) begin
      n_fail++; $display("FAIL blank_k9: got %b required %b", blank, exp_b[1]);
    end
    cyc();
    n_tests++;
    if (blank !== exp_b[0]) begin
      n_fail++; $display("FAIL blank_k10: got %b required %b", blank, exp_b[0]);
    end
    cyc(5);
    incs(1);
    n_tests++;
    if (blank !== 1'b0 || {tens, ones} !== 8'h01) begin
      n_fail++; $display("FAIL inc_clears_blank: got blank=%b %0d/%0d required 0 0/1", blank, tens, ones);
    end
    incs(2);
    pulse_mode(); incs(7);
    rst = 1'b1; cyc(); rst = 1'b0;
    n_tests++;
    if ({tens, ones, pg, set, blank, tick} !== 13'd0) begin
      n_fail++; $display("FAIL reset_mid_set: got %b required 0", {tens, ones, pg, set, blank, tick});
    end
    pulse_page();
    n_tests++;
    if (pg !== 2'd1 || {tens, ones} !== 8'h00) begin
      n_fail++; $display("FAIL reset_mm: got page=%0d %0d/%0d required 1 0/0", pg, tens, ones);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; inc = 1'b0; page = 1'b0;
    @(negedge clk);
    test_reset();
    test_set_hours();
    test_minutes_wrap();
    test_rollover();
    test_simultaneous();
    test_reset_mid_set();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_ctrl.md
# clock_ctrl

Timekeeping and display sequencer for the two-digit seven-segment clock. Keeps HH:MM:SS in BCD, runs a button-driven set-mode state machine, and schedules which time field drives the shared two-digit decoder through `o_tens`/`o_ones`. It sits between the debounced button pulses and the seven-segment decoder.

## Interface

Parameters:

- `CLK_HZ`, default 50_000_000: input clock frequency and prescaler modulus. Must be ≥2; must be even when `CLOCK_CTRL_BLINK_EN` is defined.

Ports:

- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_mode` in 1: one-cycle pulse; advances the set-mode state.
- `i_inc` in 1: one-cycle pulse; increments the field being set.
- `i_page` in 1: one-cycle pulse; cycles the displayed field while in RUN.
- `o_tens` out 4: BCD tens digit for the decoder.
- `o_ones` out 4: BCD ones digit for the decoder.
- `o_page` out 2: displayed field, 0=HH, 1=MM, 2=SS; 3 is never driven.
- `o_set` out 1: high in SET_H or SET_M.
- `o_blank` out 1: request to blank the display (blink).
- `o_sec_tick` out 1: one-cycle pulse per elapsed second.

## Operation

- **Reset values:** state RUN, time 00:00:00, prescaler 0, page 0. `o_tens`=0, `o_ones`=0, `o_page`=0, `o_set`=0, `o_blank`=0, `o_sec_tick`=0.
- **State machine:** RUN -> SET_H -> SET_M -> RUN. Each transition is taken on an `i_mode` pulse.
- **Leaving SET_M for RUN:** seconds are cleared to 00 and the prescaler to 0.
- **RUN:**
  - The prescaler counts 0..CLK_HZ-1.
  - On the edge where prescaler==CLK_HZ-1, the prescaler returns to 0, seconds increment and `o_sec_tick` is set for one cycle.
  - `i_page` advances the page 0->1->2->0.
  - `i_inc` is ignored.
- **Set states:**
  - The prescaler is held at 0 and time does not advance.
  - `i_page` is ignored and the page register is kept.
  - In SET_H, `i_inc` increments hours, wrapping 23->00.
  - In SET_M, `i_inc` increments minutes, wrapping 59->00, with no carry into hours.
- **BCD arithmetic:**
  - Each field is a tens/ones nibble pair; ones wrap 9->0 with a carry into tens.
  - Seconds wrap 59->00 with a carry into minutes.
  - Minutes wrap 59->00 with a carry into hours (RUN only).
  - Hours wrap 23->00, so 23:59:59 -> 00:00:00.
  - Digits are never outside valid BCD for their field.
- **Display scheduling:**
  - RUN shows the field selected by the page register.
  - SET_H always shows hours; SET_M always shows minutes.
  - `o_page` reports the field actually shown: 0 in SET_H, 1 in SET_M.
- **Simultaneous events:**
  - `i_mode` takes priority; an `i_inc` or `i_page` pulse in the same cycle is dropped.
  - A second tick coinciding with `i_mode` in RUN is applied, and the state moves to SET_H.
- **Reset mid-operation:** `i_rst` in any state returns every register to its reset value on the next edge.

## Timing

- Time, state and page registers update on the `i_clk` edge.
- `o_tens`, `o_ones`, `o_page`, `o_set` and `o_blank` are combinational from those registers, so there is zero added latency.
- `o_sec_tick` is registered: it is high during the cycle after the CLK_HZ-th RUN edge counted from reset release or from SET_M exit.
- A button pulse takes effect on the edge where it is sampled high. Pulses held for more than one cycle act once per cycle high.
- The prescaler width is $clog2(CLK_HZ).

## Configuration

- **Macro:** `CLOCK_CTRL_BLINK_EN`.
- **Defined:**
  - A blink counter of modulus CLK_HZ/2 runs only in the set states.
  - A phase bit toggles at each counter wrap, and `o_blank` equals the phase bit.
  - Phase and counter clear to 0 (visible) on entry to SET_H or SET_M and on every accepted `i_inc`.
  - `o_blank`=0 in RUN.
- **Undefined:** `o_blank` is tied to 0 and no blink logic is synthesized. The port remains present.

## Test plan

All scenarios use CLK_HZ=10.

- **Reset and first tick:** `i_rst` high for 2 cycles, then low.
  - All outputs are 0.
  - The first `o_sec_tick` is high exactly in cycle 10 after release; display SS shows 0/1 from then on.
- **Set hours with wrap:** `i_mode` pulse, then 25 `i_inc` pulses -> `o_set`=1, `o_page`=0, hours 01 (`o_tens`=0, `o_ones`=1).
- **Minutes wrap without carry:**
  - In SET_M with hours 05, 60 `i_inc` pulses -> minutes 00, hours still 05.
  - Then `i_mode` -> RUN with seconds 00 and the next tick 10 cycles later.
- **Full rollover:** set 23:59, return to RUN, run 60 ticks.
  - Time reads 00:00:00.
  - Page-cycling shows HH=0/0, MM=0/0, SS=0/0.
- **Simultaneous inputs:**
  - `i_mode` and `i_inc` in the same cycle in SET_H -> state SET_M, hours unchanged.
  - `i_page` in SET_M -> `o_page` stays 1.
- **Reset mid-set and blink:**
  - With `CLOCK_CTRL_BLINK_EN`, `o_blank` toggles every 5 cycles in SET_H and is 0 in RUN.
  - `i_rst` asserted during SET_M -> RUN, 00:00:00, `o_blank`=0 on the next edge.
